// File: rtl/cpu_oci_dct_packer.sv
// OCI data-trace packer: packs 2-bit trace codes LSB-first into 30-bit frames on a valid/ready port.
// Optional build macro DCT_DROP_COUNT_EN enables the saturating dropped-code counter.
//
// state | meaning
// RUN   | accepting codes, emitting full frames
// FLUSH | end of run requested, emitting any partial frame
// DRAIN | waiting for the last offered frame to be taken
// ENDED | run finished, terminal until reset
module cpu_oci_dct_packer #(
  parameter int SLOT_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4,
  localparam int BUF_W = SLOT_W * SLOTS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dt_code_valid,
  input  logic [SLOT_W-1:0] dt_code,
  input  logic              flush_req,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic              test_ending,
  output logic              test_has_ended,
  output logic [15:0]       dct_drop_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   asm_buf_q, asm_buf_d;
  logic [CNT_W-1:0]   asm_cnt_q, asm_cnt_d;
  logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d;
  logic [CNT_W-1:0]   dct_count_q, dct_count_d;
  logic               dct_valid_q, dct_valid_d;
  logic               test_ending_q, test_ending_d;
  logic               test_has_ended_q, test_has_ended_d;

  logic               out_free;
  logic               code_acc;
  logic [BUF_W-1:0]   buf_acc;
  logic [CNT_W-1:0]   cnt_acc;
  logic               load_full;
  logic               load_part;

  always_comb begin
    out_free = !dct_valid_q || dct_ready;
    code_acc = (state_q == ST_RUN) && dt_code_valid && (asm_cnt_q < SLOTS_C);

    // Assembly contents including a code accepted this cycle
    buf_acc = asm_buf_q;
    if (code_acc) begin
      buf_acc[asm_cnt_q*SLOT_W +: SLOT_W] = dt_code;
    end
    cnt_acc = asm_cnt_q + CNT_W'(code_acc);

    load_full = (state_q == ST_RUN) && (cnt_acc == SLOTS_C) && out_free;
    load_part = (state_q == ST_FLUSH) && (asm_cnt_q != '0) && out_free;
  end

  always_comb begin
    state_d          = state_q;
    asm_buf_d        = buf_acc;
    asm_cnt_d        = cnt_acc;
    dct_buffer_d     = dct_buffer_q;
    dct_count_d      = dct_count_q;
    dct_valid_d      = dct_valid_q;
    test_ending_d    = test_ending_q;
    test_has_ended_d = test_has_ended_q;

    if (load_full) begin
      dct_buffer_d = buf_acc;
      dct_count_d  = SLOTS_C;
      dct_valid_d  = 1'b1;
      asm_buf_d    = '0;
      asm_cnt_d    = '0;
    end else if (load_part) begin
      dct_buffer_d = asm_buf_q;
      dct_count_d  = asm_cnt_q;
      dct_valid_d  = 1'b1;
      asm_buf_d    = '0;
      asm_cnt_d    = '0;
    end else if (dct_ready) begin
      dct_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d       = ST_FLUSH;
          test_ending_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (asm_cnt_q == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!dct_valid_q || dct_ready) begin
          state_d          = ST_ENDED;
          test_has_ended_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_ENDED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_RUN;
      asm_buf_q        <= '0;
      asm_cnt_q        <= '0;
      dct_buffer_q     <= '0;
      dct_count_q      <= '0;
      dct_valid_q      <= 1'b0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      asm_buf_q        <= asm_buf_d;
      asm_cnt_q        <= asm_cnt_d;
      dct_buffer_q     <= dct_buffer_d;
      dct_count_q      <= dct_count_d;
      dct_valid_q      <= dct_valid_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

`ifdef DCT_DROP_COUNT_EN
  logic        code_drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    code_drop  = dt_code_valid && !code_acc;
    drop_cnt_d = drop_cnt_q;
    if (code_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dct_drop_count = drop_cnt_q;
`else
  assign dct_drop_count = '0;
`endif

  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign dct_valid      = dct_valid_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Directed bench for cpu_oci_dct_packer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        dt_code_valid;
  logic [1:0]  dt_code;
  logic        flush_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] dct_drop_count;

  int checks;
  int failures;

`ifdef DCT_DROP_COUNT_EN
  localparam logic [15:0] DROP1 = 16'd1;
`else
  localparam logic [15:0] DROP1 = 16'd0;
`endif

  cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .dt_code_valid  (dt_code_valid),
    .dt_code        (dt_code),
    .flush_req      (flush_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .dct_drop_count (dct_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  code;
    logic        flush;
    logic        ready;
    logic        e_valid;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        e_end;
    logic        e_ended;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic [1:0] code, logic flush, logic ready,
                              logic e_valid, logic [3:0] e_cnt, logic [29:0] e_buf,
                              logic e_end, logic e_ended, logic [15:0] e_drop);
    vec_t r;
    r.rst = rst; r.v = v; r.code = code; r.flush = flush; r.ready = ready;
    r.e_valid = e_valid; r.e_cnt = e_cnt; r.e_buf = e_buf;
    r.e_end = e_end; r.e_ended = e_ended; r.e_drop = e_drop;
    return r;
  endfunction

  // Expected frame for codes (start+s)%4 in slots 0..n-1
  function automatic logic [29:0] pack_mod4(int start, int n);
    logic [29:0] r;
    r = '0;
    for (int s = 0; s < n; s++) begin
      r = r | (30'((start + s) % 4) << (2 * s));
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [1:0] code, logic flush, logic ready);
    dt_code_valid = v;
    dt_code       = code;
    flush_req     = flush;
    dct_ready     = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [29:0] frame_a;
  logic        seen_valid;
  int          frames;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);

    // Full frame with ready high, then a flushed 5-code partial frame
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 14; i++)
      tbl.push_back(mk(0, 1, 2'(i % 4), 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'd2, 0, 1, 1, 4'd15, 30'h24E4E4E4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'd5, 30'h3FF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'd5, 30'h3FF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2'd1, 1, 1, 0, 0, 0, 1, 1, DROP1));

    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst;
      drive(tbl[r].v, tbl[r].code, tbl[r].flush, tbl[r].ready);
      tick();
      chk($sformatf("row%0d_valid", r), 32'(dct_valid), 32'(tbl[r].e_valid));
      chk($sformatf("row%0d_ending", r), 32'(test_ending), 32'(tbl[r].e_end));
      chk($sformatf("row%0d_ended", r), 32'(test_has_ended), 32'(tbl[r].e_ended));
      chk($sformatf("row%0d_drop", r), 32'(dct_drop_count), 32'(tbl[r].e_drop));
      if (tbl[r].e_valid) begin
        chk($sformatf("row%0d_count", r), 32'(dct_count), 32'(tbl[r].e_cnt));
        chk($sformatf("row%0d_buffer", r), 32'(dct_buffer), 32'(tbl[r].e_buf));
      end
    end
    reset = 1'b0;

    // Stall: 31 codes with ready low, frame held, one code dropped
    do_reset();
    frame_a = pack_mod4(0, 15);
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0);
      tick();
      if (i >= 14) begin
        chk($sformatf("t2_hold_valid_%0d", i), 32'(dct_valid), 32'd1);
        chk($sformatf("t2_hold_buffer_%0d", i), 32'(dct_buffer), 32'(frame_a));
        chk($sformatf("t2_hold_count_%0d", i), 32'(dct_count), 32'd15);
      end
    end
    chk("t2_drop_count", 32'(dct_drop_count), 32'(DROP1));
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    chk("t2_b2b_valid", 32'(dct_valid), 32'd1);
    chk("t2_frame2_count", 32'(dct_count), 32'd15);
    chk("t2_frame2_buffer", 32'(dct_buffer), 32'(pack_mod4(15, 15)));
    tick();
    chk("t2_after_accept_valid", 32'(dct_valid), 32'd0);

    // Flush with nothing assembled and nothing pending
    do_reset();
    drive(1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t4_ending", 32'(test_ending), 32'd1);
    seen_valid = dct_valid;
    for (int i = 0; i < 3 && !test_has_ended; i++) begin
      tick();
      seen_valid = seen_valid | dct_valid;
    end
    chk("t4_ended_within3", 32'(test_has_ended), 32'd1);
    chk("t4_no_frame", 32'(seen_valid), 32'd0);

    // 15th code coincides with flush: one full frame only
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 2'd2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t5_valid", 32'(dct_valid), 32'd1);
    chk("t5_count", 32'(dct_count), 32'd15);
    chk("t5_buffer", 32'(dct_buffer), 32'(pack_mod4(0, 15)));
    chk("t5_ending", 32'(test_ending), 32'd1);
    frames = 0;
    for (int i = 0; i < 10 && !test_has_ended; i++) begin
      tick();
      if (dct_valid) frames++;
    end
    chk("t5_ended", 32'(test_has_ended), 32'd1);
    chk("t5_extra_frames", 32'(frames), 32'd0);

    // Reset mid-frame with a frame pending
    do_reset();
    for (int i = 0; i < 22; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b0);
      tick();
    end
    chk("t6_pre_valid", 32'(dct_valid), 32'd1);
    reset = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(dct_valid), 32'd0);
    chk("t6_count", 32'(dct_count), 32'd0);
    chk("t6_buffer", 32'(dct_buffer), 32'd0);
    chk("t6_ending", 32'(test_ending), 32'd0);
    chk("t6_drop", 32'(dct_drop_count), 32'd0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t6_new_valid", 32'(dct_valid), 32'd1);
    chk("t6_new_count", 32'(dct_count), 32'd15);
    chk("t6_new_buffer", 32'(dct_buffer), 32'(pack_mod4(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
